// File: rtl/wash_program_sequencer.sv
// rtl/wash_program_sequencer.sv - program-level sequencer driving the wash phase FSM
// Latches a program, times each phase from a shared tick, re-arms for rinses, faults on timeouts.
module wash_program_sequencer #(
  parameter int CNT_W       = 16,
  parameter int WASH_TICKS  = 600,
  parameter int RINSE_TICKS = 300,
  parameter int SPIN_TICKS  = 200,
  parameter int FILL_LIMIT  = 400,
  parameter int DRAIN_LIMIT = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_req,
  input  logic [1:0] prog,
  input  logic       door,
  input  logic       filled,
  input  logic       drained,
  input  logic       abort,
  input  logic       clr_fault,
  output logic       start,
  output logic       cycle_timeout,
  output logic       spin,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [1:0] rinse_left,
  output logic [2:0] phase
);

  localparam int LIM_W = CNT_W + 1;
  localparam logic [LIM_W-1:0] QUICK_LIM  = LIM_W'(WASH_TICKS / 2);
  localparam logic [LIM_W-1:0] NORMAL_LIM = LIM_W'(WASH_TICKS);
  localparam logic [LIM_W-1:0] HEAVY_LIM  = LIM_W'(WASH_TICKS * 2);
  localparam logic [LIM_W-1:0] RINSE_LIM  = LIM_W'(RINSE_TICKS);
  localparam logic [LIM_W-1:0] SPIN_LIM   = LIM_W'(SPIN_TICKS);
  localparam logic [LIM_W-1:0] FILL_LIM   = LIM_W'(FILL_LIMIT);
  localparam logic [LIM_W-1:0] DRAIN_LIM  = LIM_W'(DRAIN_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_FILL    = 3'd2,
    S_AGITATE = 3'd3,
    S_DRAIN   = 3'd4,
    S_SPIN    = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [LIM_W-1:0] lim_q, lim_d, agit_lim;
  logic [1:0]       rinse_left_q, rinse_left_d;
  logic             rinse_pass_q, rinse_pass_d;
  logic             start_q, start_d;
  logic             cto_q, cto_d;
  logic             spin_q, spin_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic [1:0]       fcode_q, fcode_d;

  // Completion either on the current count (covers a zero limit) or on the tick landing now.
  function automatic logic reached(input logic [CNT_W-1:0] cur, input logic [CNT_W-1:0] nxt,
                                   input logic [LIM_W-1:0] lim);
    return ({1'b0, cur} == lim) || ({1'b0, nxt} == lim);
  endfunction

  assign cnt_nxt  = (tick && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  assign agit_lim = rinse_pass_q ? RINSE_LIM : lim_q;

  always_comb begin
    state_d      = state_q;
    lim_d        = lim_q;
    rinse_left_d = rinse_left_q;
    rinse_pass_d = rinse_pass_q;
    fcode_d      = fcode_q;
    start_d      = 1'b0;
    cto_d        = 1'b0;
    spin_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          case (prog)
            2'd0: begin lim_d = QUICK_LIM; rinse_left_d = 2'd0; end
            2'd2: begin lim_d = HEAVY_LIM; rinse_left_d = 2'd2; end
            default: begin lim_d = NORMAL_LIM; rinse_left_d = 2'd1; end
          endcase
          rinse_pass_d = 1'b0;
          state_d      = S_ARM;
        end
      end
      S_ARM: begin
        if (door) begin
          start_d = 1'b1;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (filled) begin
          state_d = S_AGITATE;
        end else if (reached(cnt_q, cnt_nxt, FILL_LIM)) begin
          state_d = S_FAULT;
          fcode_d = 2'b01;
        end
      end
      S_AGITATE: begin
        if (reached(cnt_q, cnt_nxt, agit_lim)) begin
          cto_d   = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained) begin
          state_d = S_SPIN;
        end else if (reached(cnt_q, cnt_nxt, DRAIN_LIM)) begin
          state_d = S_FAULT;
          fcode_d = 2'b10;
        end
      end
      S_SPIN: begin
        if (reached(cnt_q, cnt_nxt, SPIN_LIM)) begin
          spin_d = 1'b1;
          if (rinse_left_q != 2'd0) begin
            rinse_left_d = rinse_left_q - 2'd1;
            rinse_pass_d = 1'b1;
            state_d      = S_ARM;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FAULT: begin
        if (clr_fault) begin
          state_d = S_IDLE;
          fcode_d = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the busy state decided, including a pending rinse decrement.
    if (abort && (state_q inside {S_ARM, S_FILL, S_AGITATE, S_DRAIN, S_SPIN})) begin
      state_d      = S_FAULT;
      fcode_d      = 2'b11;
      start_d      = 1'b0;
      cto_d        = 1'b0;
      spin_d       = 1'b0;
      rinse_left_d = rinse_left_q;
      rinse_pass_d = rinse_pass_q;
    end

    cnt_d   = (state_d != state_q) ? '0 : cnt_nxt;
    busy_d  = state_d inside {S_ARM, S_FILL, S_AGITATE, S_DRAIN, S_SPIN};
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lim_q        <= '0;
      rinse_left_q <= 2'd0;
      rinse_pass_q <= 1'b0;
      start_q      <= 1'b0;
      cto_q        <= 1'b0;
      spin_q       <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      fcode_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lim_q        <= lim_d;
      rinse_left_q <= rinse_left_d;
      rinse_pass_q <= rinse_pass_d;
      start_q      <= start_d;
      cto_q        <= cto_d;
      spin_q       <= spin_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      fcode_q      <= fcode_d;
    end
  end

  assign start         = start_q;
  assign cycle_timeout = cto_q;
  assign spin          = spin_q;
  assign busy          = busy_q;
  assign fault         = fault_q;
  assign fault_code    = fcode_q;
  assign rinse_left    = rinse_left_q;
  assign phase         = state_q;

endmodule

// File: doc/wash_program_sequencer.md
# wash_program_sequencer

Program-level sequencer that drives the washing-machine phase FSM's control inputs: `start`, `cycle_timeout` and `spin`. It latches a wash program and times each phase from a shared tick strobe. It re-arms the phase FSM for each rinse pass and raises a fault when fill or drain exceeds its time budget. It sits between the front-panel logic and the washing-machine phase FSM, observing the same `door`, `filled` and `drained` sensors.

## Interface
Parameters:
- `CNT_W`, 16, width of the phase timer (tick counts)
- `WASH_TICKS`, 600, agitate duration for the normal program
- `RINSE_TICKS`, 300, agitate duration for each rinse pass
- `SPIN_TICKS`, 200, spin duration
- `FILL_LIMIT`, 400, maximum ticks allowed to reach `filled`
- `DRAIN_LIMIT`, 400, maximum ticks allowed to reach `drained`

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-low reset
- `tick`  in  1  one-clk timebase strobe; all timers count only on `tick`=1
- `start_req`  in  1  front-panel start request (level or pulse)
- `prog`  in  2  program: 0 quick, 1 normal, 2 heavy, 3 treated as normal
- `door`  in  1  1 = door closed
- `filled`  in  1  drum-full sensor
- `drained`  in  1  drum-empty sensor
- `abort`  in  1  user abort
- `clr_fault`  in  1  clears FAULT state
- `start`  out  1  one-clk pulse to the phase FSM
- `cycle_timeout`  out  1  one-clk pulse ending agitation
- `spin`  out  1  one-clk pulse ending spin
- `busy`  out  1  1 in any state other than IDLE and FAULT
- `fault`  out  1  1 in FAULT
- `fault_code`  out  2  01 fill timeout, 10 drain timeout, 11 abort, 00 none
- `rinse_left`  out  2  remaining rinse passes
- `phase`  out  3  current state encoding (below)

## Operation
- State encodings: IDLE=0, ARM=1, FILL=2, AGITATE=3, DRAIN=4, SPIN=5, FAULT=6. Encoding 7 is illegal and goes to IDLE next clk.
- **IDLE**
  - On `start_req`=1, latch program values and go to ARM.
  - quick: agitate limit = `WASH_TICKS`>>1, `rinse_left`=0.
  - normal: agitate limit = `WASH_TICKS`, `rinse_left`=1.
  - heavy: agitate limit = `WASH_TICKS`<<1, `rinse_left`=2.
  - The limit register is `CNT_W`+1 bits, so heavy never truncates. The program is not re-sampled until the next IDLE exit.
- **ARM**
  - Wait for `door`=1.
  - Then assert `start` for exactly one clk, clear the timer and go to FILL.
  - An open door holds ARM indefinitely with no fault.
- **FILL**
  - `filled`=1 clears the timer and goes to AGITATE.
  - If the timer reaches `FILL_LIMIT` first, go to FAULT with code 01.
- **AGITATE**
  - When the timer equals the active limit, pulse `cycle_timeout` for one clk, clear the timer and go to DRAIN.
  - The active limit is the program limit on the first pass and `RINSE_TICKS` on rinse passes.
- **DRAIN**
  - `drained`=1 clears the timer and goes to SPIN.
  - If the timer reaches `DRAIN_LIMIT` first, go to FAULT with code 10.
- **SPIN**
  - When the timer equals `SPIN_TICKS`, pulse `spin` for one clk.
  - If `rinse_left`>0, decrement it, mark the next pass as a rinse and go to ARM.
  - Otherwise go to IDLE.
- **FAULT**
  - All pulse outputs are 0.
  - `clr_fault`=1 goes to IDLE and sets `fault_code`=00.
  - `start_req` is ignored while in FAULT.
- **Abort:** `abort`=1 in any busy state goes to FAULT with code 11. Abort has priority over every other transition in the same clk.
- **Timer rules:**
  - Increments on `tick` and saturates at all-ones.
  - Cleared on every state entry.
  - Limit comparisons are equality checks against the saturating value.
  - A limit of 0 completes on the first clk of the state.

## Timing
- Reset (`rst`=0 at a rising edge) forces the following, regardless of the current state:
  - state = IDLE
  - `start` = `cycle_timeout` = `spin` = 0
  - `busy` = `fault` = 0
  - `fault_code` = 00
  - `rinse_left` = 0
  - `phase` = 0
  - timer = 0
- All outputs are registered.
- `start` rises on the clk after the ARM cycle in which `door`=1 was sampled.
- `cycle_timeout` and `spin` rise on the clk after the completing `tick` and are high for exactly one clk.
- A sensor and a limit reached in the same clk: the sensor wins, so `filled` or `drained` takes priority over the timeout.
- `start_req` held high through a program end re-launches only after one clk in IDLE. `busy` drops for at least one clk between programs.

## Test plan
- **Quick program:** `prog`=0, `door`=1, `tick` every clk, `filled` after 10 ticks, `drained` after 10 ticks → one `start` pulse, `cycle_timeout` 300 ticks after fill, `spin` 200 ticks after drain, then IDLE with `busy`=0.
- **Heavy program:** `prog`=2 → three `start` pulses; first agitate 1200 ticks, then two 300-tick agitates; `rinse_left` reads 2, 1, 0.
- **Fill timeout:** `filled` held 0 → FAULT at tick 400 with `fault_code`=01. `start_req` is then ignored; `clr_fault` returns to IDLE.
- **Boundary cases:** `abort` on the same clk as `drained` in DRAIN → FAULT code 11. `drained` on the same clk as the 400th tick → SPIN, no fault.
- **Door and reset:** door open in ARM for 50 clk → no `start` and no fault. `rst`=0 mid-AGITATE → all outputs 0 on the next clk, and a fresh `start_req` runs a full program.
